// File: rtl/boreal_ai_mailbox_if.sv
// MMIO bus between the AI host and the input mailbox.
interface boreal_ai_mailbox_if;
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output sel, wr, addr, wdata, input rdata, ack);
    modport slave  (input sel, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/boreal_ai_mailbox.sv
// Dual-slot host->VM input mailbox: host fills and commits a slot, the VM
// reads it combinationally and acks it free. Committed slots are write-locked.
module boreal_ai_mailbox #(
    parameter int WORDS = 16,
    parameter int SEQ_W = 32,
    parameter int REJ_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    boreal_ai_mailbox_if.slave       bus,
    input  logic [$clog2(WORDS)-1:0] mb_rd_idx,
    input  logic                     mb_rd_slot,
    output logic [31:0]              mb_rd_data,
    output logic                     mb_slot0_valid,
    output logic                     mb_slot1_valid,
    input  logic                     mb_slot0_ack,
    input  logic                     mb_slot1_ack,
    output logic                     irq_free
);
    localparam int IW = $clog2(WORDS);
    // Data windows start at 0x100; slot1 follows slot0 directly.
    localparam logic [11:0] WIN_LEN = 12'(8 * WORDS);

    logic [1:0][WORDS-1:0][31:0] r_mem;
    logic [1:0]                  r_valid;
    logic [1:0][SEQ_W-1:0]       r_seq;
    logic [REJ_W-1:0]            r_rej;
    logic                        r_stk_w;
    logic                        r_stk_c;
    logic                        r_irq;

    logic [11:0]      w_off;
    logic [11:0]      w_woff;
    logic             w_wr;
    logic             w_ctrl;
    logic             w_flush;
    logic             w_clear;
    logic [1:0]       w_commit;
    logic [1:0]       w_ackv;
    logic [1:0]       w_cok;
    logic [1:0]       w_crej;
    logic             w_in_win;
    logic             w_slot;
    logic [IW-1:0]    w_idx;
    logic             w_dwr;
    logic             w_wrej;
    logic [1:0]       w_nrej;
    logic [REJ_W:0]   w_rej_sum;
    logic [REJ_W-1:0] w_rej_next;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_off    = bus.addr[11:0];
    assign w_woff   = w_off - 12'h100;
    assign w_wr     = bus.sel & bus.wr;
    assign w_ctrl   = w_wr && (w_off == 12'h000);
    assign w_flush  = w_ctrl & bus.wdata[3];
    assign w_clear  = w_ctrl & bus.wdata[2];
    // A flush in the same write swallows any commit bits entirely.
    assign w_commit = (w_ctrl && !w_flush) ? bus.wdata[1:0] : 2'b00;

    assign w_in_win = (w_off >= 12'h100) && (w_woff < WIN_LEN) && (w_off[1:0] == 2'b00);
    assign w_slot   = w_woff[IW+2];
    assign w_idx    = w_woff[IW+1:2];
    assign w_dwr    = w_wr & w_in_win;

    // All lock decisions use the pre-edge valid state, so an ack in the
    // same cycle does not unlock a write or commit to that slot.
    assign w_ackv = {mb_slot1_ack, mb_slot0_ack} & r_valid;
    assign w_wrej = w_dwr & r_valid[w_slot];
    assign w_crej = w_commit & r_valid;
    assign w_cok  = w_commit & ~r_valid;

    assign w_nrej     = {1'b0, w_wrej} + {1'b0, w_crej[0]} + {1'b0, w_crej[1]};
    assign w_rej_sum  = {1'b0, r_rej} + {{(REJ_W-1){1'b0}}, w_nrej};
    assign w_rej_next = w_rej_sum[REJ_W] ? {REJ_W{1'b1}} : w_rej_sum[REJ_W-1:0];

    assign w_unused = &{1'b0, bus.addr[31:12]};

    // Slot storage, valid/lock state, sequence numbers and reject accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_valid <= '0;
            r_seq   <= '0;
            r_rej   <= '0;
            r_stk_w <= 1'b0;
            r_stk_c <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_dwr && !r_valid[w_slot])
                r_mem[w_slot][w_idx] <= bus.wdata;
            for (int s = 0; s < 2; s++) begin
                if (w_flush || w_ackv[s])
                    r_valid[s] <= 1'b0;
                else if (w_cok[s])
                    r_valid[s] <= 1'b1;
                if (w_cok[s])
                    r_seq[s] <= r_seq[s] + 1'b1;
            end
            r_irq <= |w_ackv;
            if (w_clear) begin
                r_rej   <= '0;
                r_stk_w <= 1'b0;
                r_stk_c <= 1'b0;
            end else begin
                r_rej <= w_rej_next;
                if (w_wrej)
                    r_stk_w <= 1'b1;
                if (|w_crej)
                    r_stk_c <= 1'b1;
            end
        end
    end

    // Host read mux; unmapped offsets and the write-only CTRL read as 0.
    always_comb begin
        w_rdata = '0;
        if (w_in_win) begin
            w_rdata = r_mem[w_slot][w_idx];
        end else begin
            case (w_off)
                12'h004: w_rdata = {28'b0, r_stk_c, r_stk_w, r_valid};
                12'h008: w_rdata = 32'(r_seq[0]);
                12'h00C: w_rdata = 32'(r_seq[1]);
                12'h010: w_rdata = 32'(r_rej);
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.ack        = bus.sel;
    assign mb_rd_data     = r_mem[mb_rd_slot][mb_rd_idx];
    assign mb_slot0_valid = r_valid[0];
    assign mb_slot1_valid = r_valid[1];
    assign irq_free       = r_irq;
endmodule

// File: tb/tb_boreal_ai_mailbox.sv
// Directed bench for the input mailbox with a spec-level reference model.
module tb_boreal_ai_mailbox;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rd_idx = 4'd0;
    logic        rd_slot = 1'b0;
    logic [31:0] rd_data;
    logic        v0, v1, irq;
    logic        a0 = 1'b0, a1 = 1'b0;

    boreal_ai_mailbox_if bus();

    boreal_ai_mailbox dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mb_rd_idx(rd_idx), .mb_rd_slot(rd_slot), .mb_rd_data(rd_data),
        .mb_slot0_valid(v0), .mb_slot1_valid(v1),
        .mb_slot0_ack(a0), .mb_slot1_ack(a1), .irq_free(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [2][16];
    bit   [1:0]  m_valid;
    logic [31:0] m_seq [2];
    int          m_rej;
    bit          m_sw, m_sc, m_irq;
    bit   [1:0]  pre, nv;
    int          nrej, off, ws, wi;
    bit          clr, freed;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int o;
        o = int'(a[11:0]);
        if (o >= 256 && o < 384 && o % 4 == 0) return m_mem[(o - 256) / 64][((o - 256) % 64) / 4];
        case (o)
            4:  return {28'b0, m_sc, m_sw, m_valid};
            8:  return m_seq[0];
            12: return m_seq[1];
            16: return m_rej;
            default: return 32'h0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 16; i++) m_mem[s][i] = 32'h0;
                m_seq[s] = 32'h0;
            end
            m_valid = 2'b00; m_rej = 0; m_sw = 0; m_sc = 0; m_irq = 0;
        end else begin
            pre = m_valid; nv = m_valid; nrej = 0; clr = 0; freed = 0;
            if (bus.sel && bus.wr) begin
                off = int'(bus.addr[11:0]);
                if (off == 0) begin
                    clr = bus.wdata[2];
                    if (bus.wdata[3]) nv = 2'b00;
                    else for (int s = 0; s < 2; s++)
                        if (bus.wdata[s]) begin
                            if (pre[s]) begin nrej++; m_sc = 1; end
                            else begin nv[s] = 1; m_seq[s] = m_seq[s] + 1; end
                        end
                end else if (off >= 256 && off < 384 && off % 4 == 0) begin
                    ws = (off - 256) / 64; wi = ((off - 256) % 64) / 4;
                    if (pre[ws]) begin nrej++; m_sw = 1; end
                    else m_mem[ws][wi] = bus.wdata;
                end
            end
            if (a0 && pre[0]) begin nv[0] = 0; freed = 1; end
            if (a1 && pre[1]) begin nv[1] = 0; freed = 1; end
            m_valid = nv;
            m_irq   = freed;
            if (clr) begin m_rej = 0; m_sw = 0; m_sc = 0; end
            else m_rej = (m_rej + nrej > 65535) ? 65535 : m_rej + nrej;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("slot0_valid", {31'b0, v0}, {31'b0, m_valid[0]});
            chk("slot1_valid", {31'b0, v1}, {31'b0, m_valid[1]});
            chk("irq_free", {31'b0, irq}, {31'b0, m_irq});
            chk("mmio_ack", {31'b0, bus.ack}, {31'b0, bus.sel});
            chk("mb_rd_data", rd_data, m_mem[rd_slot][rd_idx]);
            if (bus.sel) chk("rdata", bus.rdata, m_read(bus.addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic k0, input logic k1);
        @(posedge clk); #1;
        bus.sel = s; bus.wr = w; bus.addr = a; bus.wdata = d; a0 = k0; a1 = k1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0);
        #1 chk(name, bus.rdata, exp);
    endtask

    initial begin
        bus.sel = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
        idle(); idle();
        #1 rst_n = 1'b1;
        chk_en = 1;

        // Reset state
        rd_chk("reset_status", 32'h004, 32'h0);
        rd_chk("reset_seq0", 32'h008, 32'h0);
        rd_chk("reset_rej", 32'h010, 32'h0);
        rd_chk("reset_word", 32'h104, 32'h0);

        // Fill and commit slot0
        for (int i = 0; i < 16; i++) wr(32'h100 + 4 * i, 32'hA000_0000 + i);
        wr(32'h000, 32'h1);
        rd_idx = 4'd5;
        rd_chk("commit_status", 32'h004, 32'h1);
        rd_chk("commit_seq0", 32'h008, 32'h1);
        chk("vm_word5", rd_data, 32'hA000_0005);
        chk("slot0_valid_lit", {31'b0, v0}, 32'h1);

        // Locked slot: write and re-commit both rejected
        wr(32'h104, 32'h0000_DEAD);
        rd_chk("locked_word1", 32'h104, 32'hA000_0001);
        rd_chk("wrej_status", 32'h004, 32'h5);
        rd_chk("wrej_cnt", 32'h010, 32'h1);
        wr(32'h000, 32'h1);
        rd_chk("crej_status", 32'h004, 32'hD);
        rd_chk("crej_cnt", 32'h010, 32'h2);
        rd_chk("crej_seq0", 32'h008, 32'h1);

        // Consume slot0; second ack on a free slot does nothing
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        #1 chk("irq_pulse", {31'b0, irq}, 32'h1);
        chk("consumed_valid", {31'b0, v0}, 32'h0);
        idle();
        #1 chk("irq_one_cycle", {31'b0, irq}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        #1 chk("irq_free_ack", {31'b0, irq}, 32'h0);
        chk("retained_word", rd_data, 32'hA000_0005);

        // Ack + commit on valid slot1 in the same cycle: ack wins
        wr(32'h14C, 32'h0000_1234);
        wr(32'h000, 32'h2);
        rd_chk("s1_status", 32'h004, 32'hE);
        drive(1'b1, 1'b1, 32'h000, 32'h2, 1'b0, 1'b1);
        idle();
        #1 chk("ackcommit_irq", {31'b0, irq}, 32'h1);
        rd_chk("ackcommit_status", 32'h004, 32'hC);
        rd_chk("ackcommit_cnt", 32'h010, 32'h3);
        rd_chk("ackcommit_seq1", 32'h00C, 32'h1);

        // Clear, commit both, then saturate the reject counter
        wr(32'h000, 32'h4);
        wr(32'h000, 32'h3);
        rd_chk("both_status", 32'h004, 32'h3);
        for (int i = 0; i < 32767; i++) wr(32'h000, 32'h3);
        wr(32'h100, 32'h5555_5555);
        rd_chk("sat_max", 32'h010, 32'h0000_FFFF);
        wr(32'h000, 32'h3);
        rd_chk("sat_hold", 32'h010, 32'h0000_FFFF);
        wr(32'h000, 32'h4);
        rd_chk("clear_cnt", 32'h010, 32'h0);
        rd_chk("clear_status", 32'h004, 32'h3);
        // Clear together with a rejected commit: clear wins
        wr(32'h000, 32'h5);
        rd_chk("clrwin_cnt", 32'h010, 32'h0);
        rd_chk("clrwin_status", 32'h004, 32'h3);

        // Flush + commit: flush wins, SEQ unchanged, no irq
        wr(32'h000, 32'h9);
        idle();
        #1 chk("flush_irq", {31'b0, irq}, 32'h0);
        rd_chk("flush_status", 32'h004, 32'h0);
        rd_chk("flush_seq0", 32'h008, 32'h2);
        rd_chk("flush_seq1", 32'h00C, 32'h2);
        rd_chk("flush_cnt", 32'h010, 32'h0);
        rd_chk("unmapped", 32'h020, 32'h0);

        // Reset while both slots are valid
        wr(32'h000, 32'h3);
        rd_chk("prerst_seq0", 32'h008, 32'h3);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        rd_chk("rst_status", 32'h004, 32'h0);
        rd_chk("rst_seq0", 32'h008, 32'h0);
        rd_chk("rst_seq1", 32'h00C, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_vm_word", rd_data, 32'h0);
        for (int i = 0; i < 32; i++) rd_chk("rst_words", 32'h100 + 4 * i, 32'h0);

        idle(); idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
